hack_rom_loader: RTL

- UART-fed program loader upstream of the Hack instruction memory.
- Receives a framed byte stream from the UART receiver, assembles 16-bit instructions, and drives the instruction memory's synchronous write port.
- Holds the CPU in reset while a load is in progress.
- Reports completion or error so top level can release the CPU or flag the LEDs.

---
 rtl/hack_loader_pkg.sv | 24 ++
 rtl/hack_rom_loader_if.sv | 17 +
 rtl/loader_timeout.sv | 29 ++
 rtl/hack_rom_loader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hack_loader_pkg.sv
// rtl/hack_loader_pkg.sv - shared types and helpers for the Hack ROM loader
// Purpose: loader FSM state encoding, default frame marker, checksum step.
// Ports: none (package).
package hack_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Modulo-256 running sum of frame bytes after the sync marker.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/hack_rom_loader_if.sv
// rtl/hack_rom_loader_if.sv - byte stream in and instruction memory write port out
// Purpose: bundles the UART byte strobe and the memory write port.
// Ports (members): rx_data/rx_valid from the UART receiver;
//   wr_en/wr_addr/wr_data to the instruction memory.
// Modports: slave = loader side, master = UART/memory side.
interface hack_rom_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;

  modport master (output rx_data, rx_valid, input wr_en, wr_addr, wr_data);
  modport slave  (input rx_data, rx_valid, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - inter-byte idle counter for the ROM loader
// Purpose: counts idle cycles while enabled; flags the TIMEOUT_CYCLES-th one.
// Ports: clk, reset (sync, active-high); i_clear restarts the count;
//   i_enable gates counting (count held at 0 when low); o_expired.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear || !i_enable) begin
      r_count <= '0;
    end else if (!o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  // r_count holds the idle cycles already completed, so hitting
  // TIMEOUT_CYCLES-1 means the current cycle is the TIMEOUT_CYCLES-th.
  assign o_expired = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - UART-fed program loader for the Hack instruction memory
// Purpose: parses SYNC/LEN/words/CSUM frames, writes words to memory,
//   holds the CPU in reset while loading, reports done/error.
// Ports: clk, reset (sync, active-high); bus (slave: rx byte in, write port out);
//   cpu_hold, load_done (sticky), load_error (sticky), word_count.
module hack_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  reset,
  hack_rom_loader_if.slave      bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);
  // 17 bits so a 16-bit length can be compared against 2**ADDR_WIDTH.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  loader_state_t         r_state, w_state_nxt;
  logic [15:0]           r_len, w_len_nxt;
  logic [7:0]            r_hi, w_hi_nxt;
  logic [7:0]            r_sum, w_sum_nxt;
  logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic [15:0]           r_wr_data, w_wr_data_nxt;
  logic                  r_hold, w_hold_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_error, w_error_nxt;
  logic [15:0]           w_len_lo;
  logic                  w_tmo_en;
  logic                  w_expired;

  assign w_len_lo = {r_len[15:8], bus.rx_data};
  assign w_tmo_en = r_state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (bus.rx_valid),
    .i_enable  (w_tmo_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_hi      <= '0;
      r_sum     <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_hi      <= w_hi_nxt;
      r_sum     <= w_sum_nxt;
      r_count   <= w_count_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_hold    <= w_hold_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_hi_nxt      = r_hi;
    w_sum_nxt     = r_sum;
    w_count_nxt   = r_count;
    w_wr_en_nxt   = 1'b0;
    w_wr_data_nxt = r_wr_data;
    w_hold_nxt    = r_hold;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;

    // The word count advances during the write pulse itself, after
    // wr_addr has used the old value.
    if (r_wr_en) w_count_nxt = r_count + (ADDR_WIDTH + 1)'(1);

    case (r_state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          w_state_nxt = LEN_HI;
          w_done_nxt  = 1'b0;
          w_error_nxt = 1'b0;
          w_count_nxt = '0;
          w_sum_nxt   = '0;
          w_hold_nxt  = 1'b1;
        end
      end
      LEN_HI: begin
        if (bus.rx_valid) begin
          w_len_nxt[15:8] = bus.rx_data;
          w_sum_nxt       = csum_add(r_sum, bus.rx_data);
          w_state_nxt     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (bus.rx_valid) begin
          w_len_nxt[7:0] = bus.rx_data;
          w_sum_nxt      = csum_add(r_sum, bus.rx_data);
          if ({1'b0, w_len_lo} > CAPACITY) w_state_nxt = ERROR;
          else if (w_len_lo == 16'd0)      w_state_nxt = CHECK;
          else                             w_state_nxt = DATA_HI;
        end
      end
      DATA_HI: begin
        if (bus.rx_valid) begin
          w_hi_nxt    = bus.rx_data;
          w_sum_nxt   = csum_add(r_sum, bus.rx_data);
          w_state_nxt = DATA_LO;
        end
      end
      DATA_LO: begin
        if (bus.rx_valid) begin
          w_sum_nxt     = csum_add(r_sum, bus.rx_data);
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = {r_hi, bus.rx_data};
          // r_count is settled here (strobes are >= 2 cycles apart), so
          // r_count+1 is the count after this word.
          if ({1'b0, r_len} == 17'(r_count) + 17'd1) w_state_nxt = CHECK;
          else                                       w_state_nxt = DATA_HI;
        end
      end
      CHECK: begin
        if (bus.rx_valid) begin
          w_state_nxt = (bus.rx_data == r_sum) ? DONE : ERROR;
        end
      end
      DONE: begin
        w_done_nxt  = 1'b1;
        w_hold_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      ERROR: begin
        w_error_nxt = 1'b1;
        w_hold_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // A byte arriving in the expiry cycle takes precedence.
    if (w_tmo_en && w_expired && !bus.rx_valid) w_state_nxt = ERROR;
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_count[ADDR_WIDTH-1:0];
  assign bus.wr_data = r_wr_data;
  assign cpu_hold    = r_hold;
  assign load_done   = r_done;
  assign load_error  = r_error;
  assign word_count  = r_count;
endmodule
